prefetch_queue: RTL and testbench

//  Byte-granular code prefetch queue between the bus unit and the decoder.

---
 rtl/prefetch_pkg.sv | 16 +
 rtl/prefetch_queue_if.sv | 36 +++
 rtl/prefetch_queue_window.sv | 34 +++
 rtl/prefetch_queue.sv | 95 +++++++++
 tb/tb_prefetch_queue.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_pkg
//  Purpose  : Shared constants and types for the code prefetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
package prefetch_pkg;

    localparam int WINDOW_BYTES    = 16;
    localparam int MAX_INSN_BYTES  = 15;
    localparam int FETCH_BYTES_MAX = 4;

    typedef logic [7:0] code_byte_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_queue_if
//  Purpose  : Bus-unit / decoder side signals of the prefetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface prefetch_queue_if;
    import prefetch_pkg::*;

    logic        i_flush;
    logic [31:0] i_flush_eip;
    logic        i_fetch_valid;
    logic        o_fetch_ready;
    logic [31:0] i_fetch_data;
    logic [2:0]  i_fetch_count;
    code_byte_t  o_instruction [0:WINDOW_BYTES-1];
    logic [4:0]  o_window_count;
    logic        i_consume_valid;
    logic [4:0]  i_consume_bytes;
    logic        o_consume_error;
    logic [31:0] o_decode_eip;

    modport slave (
        input  i_flush, i_flush_eip, i_fetch_valid, i_fetch_data, i_fetch_count,
        input  i_consume_valid, i_consume_bytes,
        output o_fetch_ready, o_instruction, o_window_count, o_consume_error, o_decode_eip
    );

    modport master (
        output i_flush, i_flush_eip, i_fetch_valid, i_fetch_data, i_fetch_count,
        output i_consume_valid, i_consume_bytes,
        input  o_fetch_ready, o_instruction, o_window_count, o_consume_error, o_decode_eip
    );

endinterface
`default_nettype wire

// File: rtl/prefetch_queue_window.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_queue_window
//  Purpose  : Rotates the circular byte store by rd_ptr into the 16-byte
//             decoder window, zeroing lanes beyond the valid count.
//  Revision : 1.0 - initial release
// ============================================================================
module prefetch_queue_window
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  code_byte_t                 i_mem [DEPTH],
    input  wire logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    input  wire logic [$clog2(DEPTH):0]   i_count,
    output code_byte_t                 o_window [0:WINDOW_BYTES-1],
    output logic [4:0]                 o_window_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointer arithmetic truncates to PTR_W bits, giving the modulo-DEPTH wrap.
    for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_lane
        logic [PTR_W-1:0] w_idx;
        assign w_idx       = i_rd_ptr + PTR_W'(i);
        assign o_window[i] = (CNT_W'(i) < i_count) ? i_mem[w_idx] : 8'h00;
    end

    assign o_window_count = (i_count >= CNT_W'(WINDOW_BYTES)) ? 5'(WINDOW_BYTES)
                                                                : i_count[4:0];

endmodule
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : prefetch_queue
//  Purpose  : Byte-granular code prefetch queue between bus unit and decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int          DEPTH       = 32,
    parameter int          FETCH_BYTES = 4,
    parameter logic [31:0] RESET_EIP   = 32'h0000_FFF0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    prefetch_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    code_byte_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_eip;
    logic             r_err;

    logic             w_ready;
    logic             w_wr_fire;
    logic [2:0]       w_wr_n;
    logic             w_consume_ok;
    logic [4:0]       w_rd_n;
    logic [4:0]       w_window_count;

    assign w_ready   = (r_count <= CNT_W'(DEPTH - FETCH_BYTES));
    assign w_wr_fire = bus.i_fetch_valid & w_ready & ~bus.i_flush
                     & (bus.i_fetch_count != 3'd0)
                     & (bus.i_fetch_count <= 3'(FETCH_BYTES));
    assign w_wr_n    = w_wr_fire ? bus.i_fetch_count : 3'd0;

    // Legality uses the pre-write window, so same-cycle writes cannot be consumed.
    assign w_consume_ok = bus.i_consume_valid & ~bus.i_flush
                        & (bus.i_consume_bytes != 5'd0)
                        & (bus.i_consume_bytes <= 5'(MAX_INSN_BYTES))
                        & (bus.i_consume_bytes <= w_window_count);
    assign w_rd_n       = w_consume_ok ? bus.i_consume_bytes : 5'd0;

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_BYTES; k++) begin
            if (3'(k) < w_wr_n) begin
                r_mem[r_wr_ptr + PTR_W'(k)] <= bus.i_fetch_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_eip    <= RESET_EIP;
            r_err    <= 1'b0;
        end else if (bus.i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_eip    <= bus.i_flush_eip;
            r_err    <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_rd_n);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_wr_n);
            r_count  <= r_count + CNT_W'(w_wr_n) - CNT_W'(w_rd_n);
            r_eip    <= r_eip + 32'(w_rd_n);
            r_err    <= bus.i_consume_valid & ~w_consume_ok;
        end
    end

    prefetch_queue_window #(
        .DEPTH (DEPTH)
    ) u_window (
        .i_mem          (r_mem),
        .i_rd_ptr       (r_rd_ptr),
        .i_count        (r_count),
        .o_window       (bus.o_instruction),
        .o_window_count (w_window_count)
    );

    assign bus.o_fetch_ready   = w_ready;
    assign bus.o_window_count  = w_window_count;
    assign bus.o_consume_error = r_err;
    assign bus.o_decode_eip    = r_eip;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prefetch_queue
//  Purpose  : Directed and randomized checks of prefetch_queue against a
//             byte-queue reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_queue;
    import prefetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prefetch_queue_if bus ();

    prefetch_queue #(
        .DEPTH       (32),
        .FETCH_BYTES (4),
        .RESET_EIP   (32'h0000_FFF0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned m_q[$];
    logic [31:0]  m_eip;
    logic         m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_eip = 32'h0000_FFF0;
        m_err = 1'b0;
    endtask

    task automatic check_all();
        int cnt;
        cnt = m_q.size();
        check("window_count", 32'(bus.o_window_count), (cnt > 16) ? 16 : cnt);
        check("fetch_ready", 32'(bus.o_fetch_ready), ((32 - cnt) >= 4) ? 1 : 0);
        check("consume_error", 32'(bus.o_consume_error), 32'(m_err));
        check("decode_eip", bus.o_decode_eip, m_eip);
        for (int i = 0; i < 16; i++)
            check("instruction", 32'(bus.o_instruction[i]), (i < cnt) ? 32'(m_q[i]) : 0);
    endtask

    task automatic drive_idle();
        bus.i_flush         = 1'b0;
        bus.i_flush_eip     = 32'h0;
        bus.i_fetch_valid   = 1'b0;
        bus.i_fetch_data    = 32'h0;
        bus.i_fetch_count   = 3'd0;
        bus.i_consume_valid = 1'b0;
        bus.i_consume_bytes = 5'd0;
    endtask

    // Drive one cycle, advance the model, then check at the following negedge.
    task automatic cycle(input logic fl, input logic [31:0] feip, input logic fv,
                         input logic [31:0] fd, input logic [2:0] fc,
                         input logic cv, input logic [4:0] cb);
        int  cnt;
        int  wc;
        bit  rdy;
        bit  ok;
        bus.i_flush         = fl;
        bus.i_flush_eip     = feip;
        bus.i_fetch_valid   = fv;
        bus.i_fetch_data    = fd;
        bus.i_fetch_count   = fc;
        bus.i_consume_valid = cv;
        bus.i_consume_bytes = cb;
        cnt = m_q.size();
        wc  = (cnt > 16) ? 16 : cnt;
        rdy = (32 - cnt) >= 4;
        if (fl) begin
            m_q.delete();
            m_eip = feip;
            m_err = 1'b0;
        end else begin
            ok    = cv && (cb >= 1) && (cb <= 15) && (int'(cb) <= wc);
            m_err = cv && !ok;
            if (ok) begin
                repeat (int'(cb)) void'(m_q.pop_front());
                m_eip = m_eip + 32'(cb);
            end
            if (fv && rdy && (fc >= 1) && (fc <= 4))
                for (int k = 0; k < int'(fc); k++) m_q.push_back(fd[8*k +: 8]);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic write4(input logic [31:0] fd);
        cycle(1'b0, 32'h0, 1'b1, fd, 3'd4, 1'b0, 5'd0);
    endtask

    task automatic consume(input logic [4:0] cb);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1, cb);
    endtask

    initial begin
        int          wc;
        logic [4:0]  cb;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Four 4-byte writes fill the window with 00..0F
        write4(32'h0302_0100);
        write4(32'h0706_0504);
        write4(32'h0B0A_0908);
        write4(32'h0F0E_0D0C);
        check("t1_wc", 32'(bus.o_window_count), 16);
        check("t1_i0", 32'(bus.o_instruction[0]), 32'h00);
        check("t1_i15", 32'(bus.o_instruction[15]), 32'h0F);
        check("t1_eip", bus.o_decode_eip, 32'h0000_FFF0);

        // Consume 3 while writing 10..13
        cycle(1'b0, 32'h0, 1'b1, 32'h1312_1110, 3'd4, 1'b1, 5'd3);
        check("t2_i0", 32'(bus.o_instruction[0]), 32'h03);
        check("t2_eip", bus.o_decode_eip, 32'h0000_FFF3);

        // Fill to 29, dropped write, then consume 2 reopens the queue
        write4(32'h1716_1514);
        write4(32'h1B1A_1918);
        write4(32'h1F1E_1D1C);
        check("t3_ready_low", 32'(bus.o_fetch_ready), 0);
        write4(32'hEEEE_EEEE);
        consume(5'd2);
        check("t3_ready_high", 32'(bus.o_fetch_ready), 1);

        // Shrink to 5 bytes, then over-length and zero-length consumes
        consume(5'd15);
        consume(5'd7);
        check("t4_wc", 32'(bus.o_window_count), 5);
        consume(5'd6);
        check("t4_err", 32'(bus.o_consume_error), 1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b0, 5'd0);
        check("t4_err_pulse", 32'(bus.o_consume_error), 0);
        consume(5'd0);
        check("t4_err_zero", 32'(bus.o_consume_error), 1);

        // Flush beats write and consume in the same cycle
        cycle(1'b1, 32'h0000_1234, 1'b1, 32'hAABB_CCDD, 3'd4, 1'b1, 5'd2);
        check("t5_eip", bus.o_decode_eip, 32'h0000_1234);
        check("t5_wc", 32'(bus.o_window_count), 0);
        check("t5_err", 32'(bus.o_consume_error), 0);

        // Walk rd_ptr to 28 and read a window that wraps the buffer
        for (int b = 0; b < 7; b++) write4({4{8'(b)}});
        consume(5'd15);
        consume(5'd13);
        write4(32'hA3A2_A1A0);
        write4(32'hA7A6_A5A4);
        cycle(1'b0, 32'h0, 1'b1, 32'h0000_A9A8, 3'd2, 1'b0, 5'd0);
        check("t6_i0", 32'(bus.o_instruction[0]), 32'hA0);
        check("t6_i9", 32'(bus.o_instruction[9]), 32'hA9);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check("t6_rst_wc", 32'(bus.o_window_count), 0);
        check("t6_rst_eip", bus.o_decode_eip, 32'h0000_FFF0);
        check("t6_rst_ready", 32'(bus.o_fetch_ready), 1);
        check("t6_rst_i0", 32'(bus.o_instruction[0]), 0);
        model_reset();
        drive_idle();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            wc = (m_q.size() > 16) ? 16 : m_q.size();
            if (($urandom_range(0, 3) != 0) && (wc > 0))
                cb = 5'($urandom_range(1, (wc > 15) ? 15 : wc));
            else
                cb = 5'($urandom_range(0, 16));
            cycle(($urandom_range(0, 31) == 0), $urandom,
                  ($urandom_range(0, 9) < 7), $urandom,
                  3'($urandom_range(0, 5)),
                  ($urandom_range(0, 1) == 1), cb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
